cnt_arb: RTL and testbench
==========================

# cnt_arb

Shared-counter arbiter and sequencer for the counter datapath. Up to NREQ requesters contend for a single WIDTH-bit counter register. A round-robin arbiter grants ownership to one requester at a time, and the owner issues increment, clear or load commands. The block sits between requesting control logic and the shared counter and gives every requester bounded, fair access.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, counter width in bits
- HOLD_MAX, 4, maximum commands one owner may issue per grant (1..15)

- CLK  input  1  clock, all logic on posedge
- RST  input  1  synchronous reset, active-high
- req  input  NREQ  per-requester request, level
- op  input  2*NREQ  per-requester command; slice i is op[2i+1:2i]: 00 nop, 01 inc, 10 clr, 11 load
- din  input  NREQ*WIDTH  per-requester load value; slice i is din[WIDTH*i +: WIDTH]
- gnt  output  NREQ  one-hot grant, registered
- owner  output  3  index of current owner; valid while busy
- busy  output  1  high in GRANT state
- cnt  output  WIDTH  shared counter value
- cnt_wrap  output  1  one-cycle pulse when an inc wraps cnt from all-ones to 0

## Operation
- Reset: clock and reset are fixed. One clock, CLK; RST is synchronous and active-high. At a posedge with RST=1, all outputs and state go to their reset values.
  - gnt=0, owner=0, busy=0, cnt=0, cnt_wrap=0.
  - State=IDLE, rr_ptr=0, hold_cnt=0.
- FSM states: IDLE, GRANT, GAP.
  - IDLE: if any req bit is high, select the winner w, set gnt=onehot(w), owner=w and hold_cnt=0, then go to GRANT. Otherwise stay in IDLE.
  - Winner selection searches upward from rr_ptr, wrapping modulo NREQ. The first requester with req high wins.
  - GRANT: the owner command is op slice owner. It is applied only when req[owner]=1.
    - A non-nop command increments hold_cnt.
    - Release occurs when req[owner]=0, or when a non-nop command brings hold_cnt to HOLD_MAX.
    - On release: gnt=0, busy=0, rr_ptr=(owner+1) mod NREQ, go to GAP.
  - GAP: one mandatory idle cycle, then go to IDLE. Requests are ignored in GAP.
- Counter commands take effect on the edge that ends the command cycle:
  - inc: cnt=cnt+1, modulo 2^WIDTH.
  - clr: cnt=0.
  - load: cnt=din slice owner.
- Commands from non-owners are ignored, including any op driven while gnt is low.
- cnt_wrap=1 only for the cycle after an inc taken at cnt=2^WIDTH-1; it is 0 otherwise.
- cnt holds its value across grants and GAP; only RST, clr and load change it apart from inc.
- If RST is asserted mid-grant, reset takes priority. The pending command is discarded and the reset values apply next cycle.

## Timing
- Request to grant: req high in IDLE at edge N gives gnt high after edge N.
- Grant must not arrive faster than this: 1 cycle from IDLE, or 2 cycles if the request arrives while the FSM is in GAP.
- Command latency: a command valid with gnt high in cycle C is visible on cnt after the edge ending cycle C.
- The last allowed command (HOLD_MAX-th) executes, and gnt falls in the same cycle that cnt updates.
- Minimum turnaround between different owners: the release cycle, then GAP, then IDLE, then the new gnt. That is 2 dead cycles.
- Worst-case wait for any requester is bounded by (NREQ-1)*(HOLD_MAX+2) cycles plus arbitration.

## Configuration
- CNT_ARB_PRIORITY_EN defined:
  - Requester 0 is high priority. In IDLE, if req[0]=1, requester 0 wins regardless of rr_ptr.
  - rr_ptr is not updated after a requester-0 grant.
  - Requesters 1..NREQ-1 rotate round-robin among themselves.
- Not defined: pure round-robin for all requesters, as described in Operation.

## Test plan
- Reset and basic grant: assert RST for 2 cycles while req=4'b1111. Expect gnt=0 and cnt=0 during reset. After release, expect gnt=4'b0001 at the first edge and owner=0.
- Hold limit: req0 held high with op0=inc continuously, HOLD_MAX=4. Expect cnt to go 0→4 over 4 cycles, gnt[0] to fall with the 4th update, then GAP, then gnt[0] again.
- Round-robin: all req high, each owner issues one inc then drops its req for one cycle. Expect grant order 0,1,2,3,0, each separated by 2 dead cycles, and cnt to advance by 1 per grant.
- Wrap and load:
  - Owner 2 loads 8'hFE, then issues inc, inc. Expect cnt=FE, FF, 00, with cnt_wrap high only for the cycle cnt=00.
  - clr then gives cnt=0.
- Non-owner ignored: owner=1; requester 3 drives op=clr with req3=1 while cnt=8'h05. Expect cnt unchanged at 05 and gnt unchanged.
- Mid-grant reset and priority macro:
  - Assert RST during owner 1 inc at cnt=7. Expect cnt=0, gnt=0, and the inc discarded.
  - With CNT_ARB_PRIORITY_EN and rr_ptr=2, req=4'b1101: expect gnt=4'b0001.

Source files
------------

// File: rtl/cnt_arb.sv
// cnt_arb: round-robin arbiter that hands one requester at a time ownership of a shared counter.
// Optional macro CNT_ARB_PRIORITY_EN: requester 0 wins whenever it requests in IDLE.
module cnt_arb #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [NREQ*WIDTH-1:0]   din,
  output logic [NREQ-1:0]         gnt,
  output logic [2:0]              owner,
  output logic                    busy,
  output logic [WIDTH-1:0]        cnt,
  output logic                    cnt_wrap
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t           r_state, w_stateNxt;
  logic [NREQ-1:0]  r_gnt, w_gntNxt;
  logic [2:0]       r_owner, w_ownerNxt;
  logic [2:0]       r_rrPtr, w_rrPtrNxt;
  logic [3:0]       r_hold, w_holdNxt;
  logic [WIDTH-1:0] r_cnt, w_cntNxt;
  logic             r_wrap, w_wrapNxt;

  logic [NREQ-1:0]  w_reqRot;
  logic             w_scanBit;
  logic [3:0]       w_winSum;
  logic [2:0]       w_win;
  logic             w_found;
  logic             w_ownerReq;
  logic [1:0]       w_cmd;
  logic [WIDTH-1:0] w_load;
  logic             w_release;

  // Rotate requests so offset 0 is rr_ptr; the lowest set offset is the winner.
  always_comb begin
    w_reqRot  = NREQ'({req, req} >> r_rrPtr);
    w_found   = 1'b0;
    w_win     = '0;
    w_winSum  = '0;
    w_scanBit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_scanBit = |(w_reqRot & (NREQ'(1) << k));
      if (!w_found && w_scanBit) begin
        w_found  = 1'b1;
        w_winSum = {1'b0, r_rrPtr} + 4'(k);
        if (w_winSum >= 4'(NREQ)) begin
          w_winSum = w_winSum - 4'(NREQ);
        end
        w_win = w_winSum[2:0];
      end
    end
`ifdef CNT_ARB_PRIORITY_EN
    if (req[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  always_comb begin
    w_ownerReq = |(req & (NREQ'(1) << r_owner));
    w_cmd      = 2'(op >> {r_owner, 1'b0});
    w_load     = WIDTH'(din >> (r_owner * WIDTH));
  end

  always_comb begin
    w_stateNxt = r_state;
    w_gntNxt   = r_gnt;
    w_ownerNxt = r_owner;
    w_holdNxt  = r_hold;
    w_rrPtrNxt = r_rrPtr;
    w_cntNxt   = r_cnt;
    w_wrapNxt  = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gntNxt   = NREQ'(1) << w_win;
          w_ownerNxt = w_win;
          w_holdNxt  = '0;
          w_stateNxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_ownerReq) begin
          case (w_cmd)
            2'b01: begin
              w_cntNxt  = r_cnt + 1'b1;
              w_wrapNxt = &r_cnt;
            end
            2'b10:   w_cntNxt = '0;
            2'b11:   w_cntNxt = w_load;
            default: w_cntNxt = r_cnt;
          endcase
          if (w_cmd != 2'b00) begin
            w_holdNxt = r_hold + 4'd1;
            if (w_holdNxt == 4'(HOLD_MAX)) begin
              w_release = 1'b1;
            end
          end
        end else begin
          w_release = 1'b1;
        end
        // A priority owner leaves the rotation pointer where it was.
        if (w_release) begin
          w_gntNxt   = '0;
          w_stateNxt = S_GAP;
`ifdef CNT_ARB_PRIORITY_EN
          if (r_owner != 3'd0) begin
            w_rrPtrNxt = (r_owner == 3'(NREQ-1)) ? 3'd0 : r_owner + 3'd1;
          end
`else
          w_rrPtrNxt = (r_owner == 3'(NREQ-1)) ? 3'd0 : r_owner + 3'd1;
`endif
        end
      end
      S_GAP:   w_stateNxt = S_IDLE;
      default: w_stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_rrPtr <= '0;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_stateNxt;
      r_gnt   <= w_gntNxt;
      r_owner <= w_ownerNxt;
      r_rrPtr <= w_rrPtrNxt;
      r_hold  <= w_holdNxt;
      r_cnt   <= w_cntNxt;
      r_wrap  <= w_wrapNxt;
    end
  end

  assign gnt      = r_gnt;
  assign owner    = r_owner;
  assign busy     = (r_state == S_GRANT);
  assign cnt      = r_cnt;
  assign cnt_wrap = r_wrap;

endmodule

// File: tb/tb_cnt_arb.sv
// tb_cnt_arb: directed scenarios plus random traffic for cnt_arb, checked every cycle against a behavioural model.
module tb_cnt_arb;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int HOLD_MAX = 4;
  localparam int M_IDLE   = 0;
  localparam int M_GRANT  = 1;
  localparam int M_GAP    = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  op  = '0;
  logic [31:0] din = '0;
  logic [3:0]  gnt;
  logic [2:0]  owner;
  logic        busy;
  logic [7:0]  cnt;
  logic        cnt_wrap;

  int checks   = 0;
  int failures = 0;

  int       mState = M_IDLE;
  int       mOwner = 0;
  int       mHold  = 0;
  int       mRr    = 0;
  int       mCnt   = 0;
  bit       mWrap  = 0;
  bit [3:0] mGnt   = '0;

  cnt_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .CLK(CLK), .RST(RST), .req(req), .op(op), .din(din),
    .gnt(gnt), .owner(owner), .busy(busy), .cnt(cnt), .cnt_wrap(cnt_wrap)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit reqBit(input int i);
    logic [3:0] t;
    t = req >> i;
    return t[0];
  endfunction

  // Reference model: advances one clock using the currently driven inputs.
  task automatic modelStep();
    int w;
    int c;
    logic [7:0] opSh;
    logic [31:0] dinSh;
    bit rel;
    if (RST) begin
      mState = M_IDLE; mGnt = '0; mOwner = 0; mHold = 0; mRr = 0; mCnt = 0; mWrap = 0;
      return;
    end
    mWrap = 0;
    case (mState)
      M_IDLE: begin
        w = -1;
        for (int off = 0; off < NREQ; off++) begin
          if (w < 0 && reqBit((mRr + off) % NREQ)) w = (mRr + off) % NREQ;
        end
`ifdef CNT_ARB_PRIORITY_EN
        if (req[0]) w = 0;
`endif
        if (w >= 0) begin
          mGnt = 4'(1 << w); mOwner = w; mHold = 0; mState = M_GRANT;
        end
      end
      M_GRANT: begin
        rel = 0;
        if (reqBit(mOwner)) begin
          opSh  = op >> (2 * mOwner);
          dinSh = din >> (WIDTH * mOwner);
          c = int'(opSh[1:0]);
          if (c == 1) begin
            if (mCnt == 255) mWrap = 1;
            mCnt = (mCnt + 1) % 256;
          end else if (c == 2) begin
            mCnt = 0;
          end else if (c == 3) begin
            mCnt = int'(dinSh[7:0]);
          end
          if (c != 0) begin
            mHold++;
            if (mHold == HOLD_MAX) rel = 1;
          end
        end else begin
          rel = 1;
        end
        if (rel) begin
          mGnt = '0; mState = M_GAP;
`ifdef CNT_ARB_PRIORITY_EN
          if (mOwner != 0) mRr = (mOwner + 1) % NREQ;
`else
          mRr = (mOwner + 1) % NREQ;
`endif
        end
      end
      default: mState = M_IDLE;
    endcase
  endtask

  task automatic compareAll();
    checkOutput("gnt", 32'(gnt), 32'(mGnt));
    checkOutput("busy", 32'(busy), 32'(mState == M_GRANT));
    if (mState == M_GRANT) checkOutput("owner", 32'(owner), 32'(mOwner));
    checkOutput("cnt", 32'(cnt), 32'(mCnt));
    checkOutput("cnt_wrap", 32'(cnt_wrap), 32'(mWrap));
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [7:0] o, input logic [31:0] d);
    RST = r; req = rq; op = o; din = d;
    modelStep();
    @(posedge CLK);
    #1;
    compareAll();
  endtask

  initial begin
    int order[$];
    int expOrder[5];
    logic [3:0] prevGnt;
    logic [3:0] rq;
`ifdef CNT_ARB_PRIORITY_EN
    expOrder = '{0, 0, 0, 0, 0};
`else
    expOrder = '{0, 1, 2, 3, 0};
`endif

    $display("[TB] reset and basic grant");
    applyStimulus(1'b1, 4'b1111, 8'h00, 32'h0);
    applyStimulus(1'b1, 4'b1111, 8'h00, 32'h0);
    checkOutput("rstGnt", 32'(gnt), 32'h0);
    checkOutput("rstCnt", 32'(cnt), 32'h0);
    applyStimulus(1'b0, 4'b1111, 8'h00, 32'h0);
    checkOutput("firstGnt", 32'(gnt), 32'h1);
    checkOutput("firstOwner", 32'(owner), 32'h0);

    $display("[TB] hold limit");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0001, 8'h01, 32'h0);
    checkOutput("holdCnt", 32'(cnt), 32'd4);
    checkOutput("holdRelease", 32'(gnt), 32'h0);
    applyStimulus(1'b0, 4'b0001, 8'h01, 32'h0);
    applyStimulus(1'b0, 4'b0001, 8'h01, 32'h0);
    checkOutput("holdRegrant", 32'(gnt), 32'h1);

    $display("[TB] round robin");
    applyStimulus(1'b1, 4'b0000, 8'h00, 32'h0);
    prevGnt = '0;
    for (int i = 0; i < 21; i++) begin
      rq = 4'b1111;
      if (mState == M_GRANT && mHold >= 1) rq = 4'b1111 & ~(4'b0001 << mOwner);
      applyStimulus(1'b0, rq, 8'b0101_0101, 32'h0);
      if (gnt != 4'b0000 && prevGnt == 4'b0000) order.push_back(int'(owner));
      prevGnt = gnt;
    end
    checkOutput("rrGrants", 32'(order.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) checkOutput($sformatf("rrOrder%0d", i), 32'(order[i]), 32'(expOrder[i]));
    end

    $display("[TB] wrap and load");
    applyStimulus(1'b1, 4'b0000, 8'h00, 32'h0);
    applyStimulus(1'b0, 4'b0100, 8'h00, 32'h0);
    applyStimulus(1'b0, 4'b0100, 8'b0011_0000, 32'h00FE_0000);
    checkOutput("loadFE", 32'(cnt), 32'hFE);
    applyStimulus(1'b0, 4'b0100, 8'b0001_0000, 32'h0);
    checkOutput("incFF", 32'(cnt), 32'hFF);
    applyStimulus(1'b0, 4'b0100, 8'b0001_0000, 32'h0);
    checkOutput("wrap00", 32'(cnt), 32'h00);
    checkOutput("wrapPulse", 32'(cnt_wrap), 32'h1);
    applyStimulus(1'b0, 4'b0100, 8'b0010_0000, 32'h0);
    checkOutput("clrCnt", 32'(cnt), 32'h0);
    checkOutput("clrWrapLow", 32'(cnt_wrap), 32'h0);

    $display("[TB] non-owner ignored and mid-grant reset");
    applyStimulus(1'b1, 4'b0000, 8'h00, 32'h0);
    applyStimulus(1'b0, 4'b0010, 8'h00, 32'h0);
    applyStimulus(1'b0, 4'b0010, 8'b0000_1100, 32'h0000_0500);
    applyStimulus(1'b0, 4'b1010, 8'b1000_0000, 32'h0);
    checkOutput("nonOwnerCnt", 32'(cnt), 32'h05);
    checkOutput("nonOwnerGnt", 32'(gnt), 32'b0010);
    applyStimulus(1'b0, 4'b0010, 8'b0000_1100, 32'h0000_0700);
    checkOutput("load07", 32'(cnt), 32'h07);
    applyStimulus(1'b1, 4'b0010, 8'b0000_0100, 32'h0);
    checkOutput("midRstCnt", 32'(cnt), 32'h0);
    checkOutput("midRstGnt", 32'(gnt), 32'h0);

    $display("[TB] pointer at 2 with req 1101");
    applyStimulus(1'b0, 4'b0010, 8'h00, 32'h0);
    applyStimulus(1'b0, 4'b0000, 8'h00, 32'h0);
    applyStimulus(1'b0, 4'b0000, 8'h00, 32'h0);
    applyStimulus(1'b0, 4'b1101, 8'h00, 32'h0);
`ifdef CNT_ARB_PRIORITY_EN
    checkOutput("ptr2Gnt", 32'(gnt), 32'b0001);
`else
    checkOutput("ptr2Gnt", 32'(gnt), 32'b0100);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      rq = 4'($urandom) | 4'($urandom);
      applyStimulus(1'($urandom_range(0, 63) == 0), rq, 8'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
